// File: rtl/pc_gen.sv
// Instruction-fetch program counter with stall, branch redirect, flush and a
// valid/ready fetch handshake. Define PC_MISALIGN_EN to keep raw targets and flag misaligned ones.
module pc_gen #(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC  = '0,
    parameter int                INST_BYTES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              branch_i,
    input  logic [ADDR_W-1:0] branch_pc_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] flush_pc_i,
    input  logic              fetch_ready_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic              ce_o,
`ifdef PC_MISALIGN_EN
    output logic              misalign_o,
`endif
    output logic              fetch_valid_o
);

    localparam int                LSB = $clog2(INST_BYTES);
    localparam logic [ADDR_W-1:0] INC = ADDR_W'(INST_BYTES);

    typedef enum logic {BOOT, RUN} state_t;

    state_t            state_reg;
    logic [ADDR_W-1:0] pc_reg;
    logic              ce_reg;
    logic              pend_vld_reg;
    logic [ADDR_W-1:0] pend_pc_reg;
    logic [ADDR_W-1:0] align_mask;
    logic [ADDR_W-1:0] branch_tgt;
    logic [ADDR_W-1:0] flush_tgt;
    logic              fetch_done;

    // Mask that keeps every bit above the instruction-size offset.
    genvar gi;
    generate
        for (gi = 0; gi < ADDR_W; gi++) begin : g_mask
            assign align_mask[gi] = (gi >= LSB);
        end
    endgenerate

`ifdef PC_MISALIGN_EN
    logic mis_reg;
    logic branch_mis;
    logic flush_mis;
    logic pend_mis;

    assign branch_tgt = branch_pc_i;
    assign flush_tgt  = flush_pc_i;
    assign branch_mis = |(branch_pc_i & ~align_mask);
    assign flush_mis  = |(flush_pc_i & ~align_mask);
    assign pend_mis   = |(pend_pc_reg & ~align_mask);
    assign misalign_o = mis_reg;
`else
    assign branch_tgt = branch_pc_i & align_mask;
    assign flush_tgt  = flush_pc_i & align_mask;
`endif

    assign fetch_done    = ce_reg & fetch_ready_i;
    assign pc_o          = pc_reg;
    assign ce_o          = ce_reg;
    assign fetch_valid_o = ce_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= BOOT;
            pc_reg       <= RESET_VEC;
            ce_reg       <= 1'b0;
            pend_vld_reg <= 1'b0;
            pend_pc_reg  <= '0;
`ifdef PC_MISALIGN_EN
            mis_reg      <= 1'b0;
`endif
        end else begin
`ifdef PC_MISALIGN_EN
            mis_reg <= 1'b0;
`endif
            case (state_reg)
                BOOT: begin
                    ce_reg    <= 1'b1;
                    state_reg <= RUN;
                end
                RUN: begin
                    if (flush_i) begin
                        pc_reg       <= flush_tgt;
                        pend_vld_reg <= 1'b0;
`ifdef PC_MISALIGN_EN
                        mis_reg      <= flush_mis;
`endif
                    end else if (branch_i && (fetch_ready_i || !ce_reg)) begin
                        pc_reg       <= branch_tgt;
                        pend_vld_reg <= 1'b0;
`ifdef PC_MISALIGN_EN
                        mis_reg      <= branch_mis;
`endif
                    end else if (branch_i) begin
                        // Outstanding fetch must not see pc_o move; park the target.
                        pend_pc_reg  <= branch_tgt;
                        pend_vld_reg <= 1'b1;
                    end else if (pend_vld_reg && fetch_done) begin
                        pc_reg       <= pend_pc_reg;
                        pend_vld_reg <= 1'b0;
`ifdef PC_MISALIGN_EN
                        mis_reg      <= pend_mis;
`endif
                    end else if (!stall_i && fetch_done) begin
                        pc_reg <= pc_reg + INC;
                    end
                end
                default: state_reg <= BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios from the feature list plus
// a randomized run, all checked against a cycle-level reference model.
module tb_pc_gen;

    localparam int          AW = 32;
    localparam int          IB = 4;
    localparam logic [31:0] RV = 32'h0;

    logic          clk = 1'b0;
    logic          rst, stall_i, branch_i, flush_i, fetch_ready_i;
    logic [AW-1:0] branch_pc_i, flush_pc_i, pc_o;
    logic          ce_o, fetch_valid_o, mis_w;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [AW-1:0] m_pc;
    logic          m_ce, m_run, m_mis;
    logic [AW-1:0] pend_q[$];

    always #5 clk = ~clk;

    pc_gen #(.ADDR_W(AW), .RESET_VEC(RV), .INST_BYTES(IB)) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .branch_i(branch_i),
        .branch_pc_i(branch_pc_i), .flush_i(flush_i), .flush_pc_i(flush_pc_i),
        .fetch_ready_i(fetch_ready_i), .pc_o(pc_o), .ce_o(ce_o),
`ifdef PC_MISALIGN_EN
        .misalign_o(mis_w),
`endif
        .fetch_valid_o(fetch_valid_o)
    );

`ifndef PC_MISALIGN_EN
    assign mis_w = 1'b0;
`endif

    function automatic logic [AW-1:0] tgt(input logic [AW-1:0] x);
`ifdef PC_MISALIGN_EN
        return x;
`else
        return x - (x % IB);
`endif
    endfunction

    function automatic logic odd(input logic [AW-1:0] x);
`ifdef PC_MISALIGN_EN
        return (x % IB) != 0;
`else
        return 1'b0;
`endif
    endfunction

    // Apply the fetch rules for one rising edge, using the inputs seen at that edge.
    task automatic model_edge();
        logic [AW-1:0] p;
        if (rst) begin
            m_pc = RV; m_ce = 0; m_run = 0; m_mis = 0; pend_q.delete();
        end else if (!m_run) begin
            m_run = 1; m_ce = 1; m_mis = 0;
        end else begin
            m_mis = 0;
            if (flush_i) begin
                m_pc = tgt(flush_pc_i); m_mis = odd(flush_pc_i); pend_q.delete();
            end else if (branch_i && fetch_ready_i) begin
                m_pc = tgt(branch_pc_i); m_mis = odd(branch_pc_i); pend_q.delete();
            end else if (branch_i) begin
                pend_q.delete();
                pend_q.push_back(tgt(branch_pc_i));
            end else if (pend_q.size() > 0 && fetch_ready_i) begin
                p = pend_q.pop_front();
                m_pc = p; m_mis = odd(p);
            end else if (!stall_i && fetch_ready_i) begin
                m_pc = m_pc + IB;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        stall_i = 0; branch_i = 0; flush_i = 0; fetch_ready_i = 1;
        branch_pc_i = '0; flush_pc_i = '0;
    endtask

    task automatic go_to(input logic [AW-1:0] a);
        flush_i = 1; flush_pc_i = a; step(); flush_i = 0;
    endtask

    task automatic test_reset();
        logic [AW-1:0] seq[4];
        seq = '{32'h0, 32'h4, 32'h8, 32'hC};
        idle_inputs(); rst = 1;
        step(); step();
        checks++;
        if ({pc_o, ce_o, fetch_valid_o} !== {RV, 1'b0, 1'b0}) begin
            errors++; $display("FAIL reset_state pc=%h ce=%b valid=%b want pc=%h ce=0 valid=0", pc_o, ce_o, fetch_valid_o, RV);
        end
        rst = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if ({pc_o, ce_o, fetch_valid_o, mis_w} !== {seq[i], 1'b1, 1'b1, 1'b0} || pc_o !== m_pc) begin
                errors++; $display("FAIL boot_seq%0d pc=%h ce=%b valid=%b want pc=%h ce=1 valid=1", i, pc_o, ce_o, fetch_valid_o, seq[i]);
            end
            $display("boot step %0d pc=%h ce=%b", i, pc_o, ce_o);
        end
    endtask

    task automatic test_stall();
        step();  // 0xC -> 0x10
        stall_i = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (pc_o !== 32'h10 || pc_o !== m_pc) begin
                errors++; $display("FAIL stall_hold%0d pc=%h want 00000010", i, pc_o);
            end
        end
        stall_i = 0;
        step();
        checks++;
        if (pc_o !== 32'h14 || pc_o !== m_pc) begin
            errors++; $display("FAIL stall_release pc=%h want 00000014", pc_o);
        end
        $display("stall done pc=%h", pc_o);
    endtask

    task automatic test_branch();
        go_to(32'h8);
        branch_i = 1; branch_pc_i = 32'h100; step(); branch_i = 0;
        checks++;
        if (pc_o !== 32'h100 || pc_o !== m_pc) begin
            errors++; $display("FAIL branch_taken pc=%h want 00000100", pc_o);
        end
        step();
        checks++;
        if (pc_o !== 32'h104 || pc_o !== m_pc) begin
            errors++; $display("FAIL branch_next pc=%h want 00000104", pc_o);
        end
        $display("branch done pc=%h", pc_o);
    endtask

    task automatic test_pending();
        go_to(32'h20);
        fetch_ready_i = 0;
        for (int i = 0; i < 4; i++) begin
            branch_i = (i == 0 || i == 2);
            branch_pc_i = (i == 0) ? 32'h200 : 32'h300;
            step();
            checks++;
            if (pc_o !== 32'h20 || pc_o !== m_pc) begin
                errors++; $display("FAIL pending_hold%0d pc=%h want 00000020", i, pc_o);
            end
        end
        branch_i = 0; fetch_ready_i = 1;
        step();
        checks++;
        if (pc_o !== 32'h300 || pc_o !== m_pc) begin
            errors++; $display("FAIL pending_apply pc=%h want 00000300", pc_o);
        end
        step();
        checks++;
        if (pc_o !== 32'h304) begin
            errors++; $display("FAIL pending_after pc=%h want 00000304", pc_o);
        end
        $display("pending done pc=%h", pc_o);
    endtask

    task automatic test_flush_pending();
        for (int s = 0; s < 2; s++) begin
            fetch_ready_i = 0;
            branch_i = 1; branch_pc_i = 32'h200; step(); branch_i = 0;
            stall_i = (s == 1);
            flush_i = 1; flush_pc_i = 32'h180; step(); flush_i = 0;
            checks++;
            if (pc_o !== 32'h180 || pc_o !== m_pc) begin
                errors++; $display("FAIL flush_pending_s%0d pc=%h want 00000180", s, pc_o);
            end
            stall_i = 0; fetch_ready_i = 1;
            step();
            checks++;
            if (pc_o !== 32'h184 || pc_o !== m_pc) begin
                errors++; $display("FAIL flush_discard_s%0d pc=%h want 00000184", s, pc_o);
            end
            $display("flush scenario %0d pc=%h", s, pc_o);
        end
    endtask

    task automatic test_wrap();
        go_to(32'hFFFF_FFFC);
        step();
        checks++;
        if (pc_o !== 32'h0 || pc_o !== m_pc) begin
            errors++; $display("FAIL wrap pc=%h want 00000000", pc_o);
        end
        $display("wrap pc=%h", pc_o);
    endtask

    task automatic test_misalign();
        logic [AW-1:0] want;
`ifdef PC_MISALIGN_EN
        want = 32'h102;
`else
        want = 32'h100;
`endif
        go_to(32'h8);
        branch_i = 1; branch_pc_i = 32'h102; step(); branch_i = 0;
        checks++;
        if (pc_o !== want || mis_w !== m_mis || pc_o !== m_pc) begin
            errors++; $display("FAIL misalign_load pc=%h mis=%b want pc=%h mis=%b", pc_o, mis_w, want, m_mis);
        end
        step();
        checks++;
        if (mis_w !== 1'b0 || pc_o !== want + 32'h4) begin
            errors++; $display("FAIL misalign_clear pc=%h mis=%b want pc=%h mis=0", pc_o, mis_w, want + 32'h4);
        end
        // Misaligned target parked while the fetch is outstanding
        fetch_ready_i = 0;
        branch_i = 1; branch_pc_i = 32'h401; step(); branch_i = 0;
        fetch_ready_i = 1; step();
        checks++;
        if (pc_o !== m_pc || mis_w !== m_mis) begin
            errors++; $display("FAIL misalign_pending pc=%h mis=%b want pc=%h mis=%b", pc_o, mis_w, m_pc, m_mis);
        end
        $display("misalign pc=%h mis=%b", pc_o, mis_w);
    endtask

    task automatic test_reset_mid();
        fetch_ready_i = 0;
        branch_i = 1; branch_pc_i = 32'h700; step(); branch_i = 0;
        rst = 1; step();
        checks++;
        if ({pc_o, ce_o} !== {RV, 1'b0}) begin
            errors++; $display("FAIL reset_mid pc=%h ce=%b want pc=%h ce=0", pc_o, ce_o, RV);
        end
        rst = 0; fetch_ready_i = 1;
        step(); step();
        checks++;
        if ({pc_o, ce_o} !== {32'h4, 1'b1} || pc_o !== m_pc) begin
            errors++; $display("FAIL reset_mid_discard pc=%h ce=%b want pc=00000004 ce=1", pc_o, ce_o);
        end
        $display("reset mid-op pc=%h", pc_o);
    endtask

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 400; i++) begin
            rst           = ($urandom_range(0, 59) == 0);
            stall_i       = ($urandom_range(0, 3) == 0);
            fetch_ready_i = ($urandom_range(0, 2) != 0);
            branch_i      = ($urandom_range(0, 5) == 0);
            flush_i       = ($urandom_range(0, 19) == 0);
            branch_pc_i   = $urandom;
            flush_pc_i    = $urandom;
            step();
            checks++;
            if ({pc_o, ce_o, fetch_valid_o, mis_w} !== {m_pc, m_ce, m_ce, m_mis}) begin
                errors++; bad++;
                $display("FAIL random%0d pc=%h ce=%b valid=%b mis=%b want pc=%h ce=%b mis=%b", i, pc_o, ce_o, fetch_valid_o, mis_w, m_pc, m_ce, m_mis);
            end
        end
        $display("random run 400 cycles, %0d bad", bad);
        idle_inputs(); rst = 0;
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        m_pc = RV; m_ce = 0; m_run = 0; m_mis = 0;
        test_reset();
        test_stall();
        test_branch();
        test_pending();
        test_flush_pending();
        test_wrap();
        test_misalign();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
